// File: rtl/seq_det_pkg.sv
`default_nettype none
//==============================================================================
// Package  : seq_det_pkg
// Desc     : Shared types and width helpers for the sequence-detector
//            controller: FSM state encoding, default widths and a helper
//            that sizes a counter for a given maximum value.
// Revision : 1.0 - initial release
//==============================================================================
package seq_det_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_BIT_CNT_W = cnt_width(DEF_WORD_W - 1);
  localparam int DEF_FILL_W    = cnt_width(DEF_PAT_W);

endpackage
`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface : seq_det_ctrl_if
// Desc      : Word stream valid/ready handshake between a word producer
//             (master) and the sequence-detector controller (slave).
// Revision  : 1.0 - initial release
//==============================================================================
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
//==============================================================================
// Module   : seq_det_core
// Desc     : Serial pattern detector. Keeps a bit history and a fill count
//            of bits seen since frame start (or since the last match when
//            overlapping matches are disabled), and raises a registered
//            match pulse one cycle after the completing bit.
// Revision : 1.0 - initial release
//==============================================================================
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit,
  output logic             match
);

  localparam int FILL_W = cnt_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;

  // Compare the incoming bit plus history against the pattern; update state.
  always_comb begin
    hist_n  = {hist_q, bit_in};
    fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit     = bit_en && !clr && (fill_n >= FILL_FULL) && (hist_n == pattern);
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en) begin
      hist_d  = hist_n[PAT_W-2:0];
      // Without overlap, bits of a matched window may not start a new match.
      fill_d  = (hit && !overlap) ? '0 : fill_n;
      match_d = hit;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : seq_det_ctrl
// Desc     : Frame controller: accepts words over valid/ready, serializes
//            them MSB-first into seq_det_core, counts matches per frame with
//            saturation and pulses done when the last bit of a frame has
//            been consumed.
// Revision : 1.0 - initial release
//==============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  seq_det_ctrl_if.slave       s_if,
  input  logic [PAT_W-1:0]    cfg_pattern,
  input  logic                cfg_overlap,
  output logic                ser_bit,
  output logic                match,
  output logic [CNT_W-1:0]    match_count,
  output logic                done,
  output logic                busy
);

  localparam int BC_W = cnt_width(WORD_W - 1);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic handshake;
  logic core_clr;
  logic core_bit_en;
  logic core_hit;

  assign handshake   = s_if.s_valid && s_ready_q && (state_q == ST_IDLE);
  // Only the first word of a frame restarts detection; later words extend it.
  assign core_clr    = handshake && !busy_q;
  assign core_bit_en = (state_q == ST_SHIFT);

  seq_det_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (core_clr),
    .bit_en  (core_bit_en),
    .bit_in  (sreg_q[WORD_W-1]),
    .pattern (pattern_q),
    .overlap (overlap_q),
    .hit     (core_hit),
    .match   (match)
  );

  // Next-state logic for the frame FSM, shift register and match counter.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    s_ready_d = s_ready_q;
    busy_d    = busy_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        if (handshake) begin
          sreg_d    = s_if.s_data;
          bit_cnt_d = BC_LAST;
          last_d    = s_if.s_last;
          s_ready_d = 1'b0;
          state_d   = ST_SHIFT;
          if (!busy_q) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            count_d   = '0;
            busy_d    = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        sreg_d    = sreg_q << 1;
        bit_cnt_d = bit_cnt_q - BC_W'(1);
        if (bit_cnt_q == '0) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_IDLE;
            s_ready_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy_d    = 1'b0;
        s_ready_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b0;
      end
    endcase

    // Hits only occur in SHIFT, so this never collides with the frame clear.
    if (core_hit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      count_q   <= count_d;
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign ser_bit      = (state_q == ST_SHIFT) && sreg_q[WORD_W-1];
  assign done         = (state_q == ST_DONE);
  assign busy         = busy_q;
  assign match_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_seq_det_ctrl
// Desc     : Self-checking bench for seq_det_ctrl. Directed frames from the
//            block's test plan plus randomized frames, all compared against
//            a bit-list reference model of the matching rules.
// Revision : 1.0 - initial release
//==============================================================================
module tb_seq_det_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              ser_bit;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              done;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [WORD_W-1:0] fw [64];

  seq_det_ctrl_if #(.WORD_W(WORD_W)) s_if ();

  seq_det_ctrl #(
    .WORD_W (WORD_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .ser_bit     (ser_bit),
    .match       (match),
    .match_count (match_count),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, s_if.s_ready, 0);
    chk({tag, "_ser"},   ser_bit, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_count"}, match_count, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Sends one frame of fw[0..nwords-1] and checks every cycle against a model
  // that keeps the frame's bit list and re-scans the window ending at each bit.
  // Call at a negedge; returns at the negedge after the done cycle.
  task automatic run_frame(input logic [PAT_W-1:0] pat, input bit ov,
                           input int nwords, input bit rnd);
    bit fb[$];
    int last_pos;
    int exp_cnt;
    int n;
    int gap;
    int wait_cyc;
    bit hit;
    bit prev_hit;
    logic [WORD_W-1:0] word;
    last_pos    = 0;
    exp_cnt     = 0;
    cfg_pattern = pat;
    cfg_overlap = ov;
    for (int w = 0; w < nwords; w++) begin
      if (rnd) begin
        gap = $urandom_range(0, 3);
        s_if.s_valid = 1'b0;
        repeat (gap) begin
          s_if.s_data = WORD_W'($urandom);
          @(negedge clk);
        end
      end
      word          = fw[w];
      s_if.s_valid  = 1'b1;
      s_if.s_data   = word;
      s_if.s_last   = (w == nwords - 1);
      wait_cyc      = 0;
      while (!s_if.s_ready && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (!s_if.s_ready) begin
        chk("hs_timeout", 0, 1);
        s_if.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      prev_hit = 1'b0;
      for (int k = 0; k < WORD_W; k++) begin
        @(negedge clk);
        if (k == 0) begin
          if (!rnd && (w + 1 < nwords)) begin
            // Keep valid high with the next word while the DUT is shifting.
            s_if.s_data = fw[w+1];
            s_if.s_last = (w + 1 == nwords - 1);
          end else begin
            s_if.s_valid = 1'b0;
            s_if.s_data  = WORD_W'($urandom);
          end
          if (rnd) begin
            cfg_pattern = PAT_W'($urandom);
            cfg_overlap = 1'($urandom);
          end
        end
        chk("ser_bit",  ser_bit, word[WORD_W-1-k]);
        chk("match",    match, prev_hit);
        chk("count",    match_count, exp_cnt);
        chk("ready_lo", s_if.s_ready, 0);
        chk("busy",     busy, 1);
        chk("done_lo",  done, 0);
        fb.push_back(word[WORD_W-1-k]);
        n   = fb.size();
        hit = 1'b0;
        if (n - last_pos >= PAT_W) begin
          hit = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (fb[n-PAT_W+i] != pat[PAT_W-1-i]) hit = 1'b0;
        end
        if (hit && !ov) last_pos = n;
        if (hit && exp_cnt < CNT_MAX) exp_cnt++;
        prev_hit = hit;
      end
      @(negedge clk);
      chk("match_end", match, prev_hit);
      chk("count_end", match_count, exp_cnt);
      chk("done",      done, (w == nwords - 1));
      chk("busy_end",  busy, 1);
      chk("ready_end", s_if.s_ready, (w != nwords - 1));
    end
    @(negedge clk);
    chk("post_done",  done, 0);
    chk("post_busy",  busy, 0);
    chk("post_count", match_count, exp_cnt);
    chk("post_ready", s_if.s_ready, 1);
  endtask

  initial begin
    int seen;
    int wait_cyc;
    rst          = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    cfg_pattern  = '0;
    cfg_overlap  = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", s_if.s_ready, 1);
    @(negedge clk);

    // Overlapping matches within one word.
    fw[0] = 8'b1101_1011;
    run_frame(4'b1101, 1'b1, 1, 1'b0);
    chk("ov_total", match_count, 2);

    // Same word, non-overlapping.
    run_frame(4'b1101, 1'b0, 1, 1'b0);
    chk("nov_total", match_count, 1);

    // Match straddling a word boundary, valid held high through SHIFT.
    fw[0] = 8'b0000_0011;
    fw[1] = 8'b0100_0000;
    run_frame(4'b1101, 1'b1, 2, 1'b0);
    chk("xword_total", match_count, 1);

    // Counter saturation.
    for (int i = 0; i < 40; i++) fw[i] = 8'hFF;
    run_frame(4'b1111, 1'b1, 40, 1'b0);
    chk("sat_total", match_count, 255);

    // Asynchronous reset in the middle of a frame.
    cfg_pattern  = 4'b1101;
    cfg_overlap  = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'b1101_1011;
    s_if.s_last  = 1'b1;
    wait_cyc     = 0;
    while (!s_if.s_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("abort_hs_ready", s_if.s_ready, 1);
    @(posedge clk);
    repeat (4) @(negedge clk);
    s_if.s_valid = 1'b0;
    chk("abort_pre_ser",  ser_bit, 1);
    chk("abort_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    fw[0] = 8'b1101_0000;
    run_frame(4'b1101, 1'b1, 1, 1'b0);
    chk("after_abort_total", match_count, 1);

    // Randomized frames with gaps and mid-frame configuration noise.
    for (int f = 0; f < 25; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) fw[i] = WORD_W'($urandom);
      run_frame(PAT_W'($urandom), 1'($urandom), nw, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Frame-level controller that feeds the serial sequence detector from a parallel word stream. It accepts words over a valid/ready handshake and serializes each word MSB-first into a programmable-pattern bit detector. It counts pattern matches across the whole frame and reports the count with a one-cycle `done` pulse. It sits between a word-wide producer (host/DMA side) and the single-bit detection datapath.

## Interface
- `WORD_W`, 8, input word width, ≥2.
- `PAT_W`, 4, pattern length in bits, 2..WORD_W.
- `CNT_W`, 8, match counter width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_pattern`  in  PAT_W  pattern; first-received bit is compared against the MSB. Latched at frame start.
- `cfg_overlap`  in  1  1 = overlapping matches allowed. Latched at frame start.
- `s_valid`  in  1  producer word valid.
- `s_ready`  out  1  controller can accept a word (registered).
- `s_data`  in  WORD_W  word, sent MSB first.
- `s_last`  in  1  word is last of frame.
- `ser_bit`  out  1  bit currently presented to detector (debug/observe).
- `match`  out  1  one-cycle pulse per detected match.
- `match_count`  out  CNT_W  matches in current/last frame.
- `done`  out  1  one-cycle pulse, frame complete.
- `busy`  out  1  frame in progress (first word accepted through `done`).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state IDLE, `s_ready`=0, `ser_bit`=0, `match`=0, `match_count`=0, `done`=0, `busy`=0, history/fill=0.
- IDLE:
  - `s_ready`=1 from the first cycle after `rst` deasserts.
  - Handshake is `s_valid & s_ready`. On handshake, load the shift register with `s_data` and set `bit_cnt`=WORD_W-1. Latch `s_last`. Go to SHIFT. Set `s_ready`=0.
  - If no frame is active, the handshake also:
    - latches `cfg_pattern` and `cfg_overlap`;
    - clears history, fill and `match_count`;
    - sets `busy`=1.
  - `s_data` is sampled only on handshake.
- SHIFT:
  - Each cycle: `ser_bit` = shift-register MSB, which is consumed by the detector. Shift left and decrement `bit_cnt`.
  - At `bit_cnt`=0: if latched last, go to DONE; else go to IDLE and set `s_ready`=1.
- DONE: `done`=1 for one cycle. `busy` clears at the end of the cycle. Go to IDLE, `s_ready`=1. `match_count` holds until the next frame's first handshake.
- Detector (in `seq_det_core`):
  - `hist_n = {hist[PAT_W-2:0], bit}`.
  - `fill` counts bits since frame start or since the last match in non-overlap mode; it saturates at PAT_W.
  - A match requires `fill_n ≥ PAT_W` and `hist_n == pattern`.
  - History spans word boundaries within a frame.
  - Non-overlap mode: a match resets `fill` to 0.
- `match_count` increments on each match and saturates at 2^CNT_W-1 (no wrap).
- An asynchronous reset mid-frame aborts immediately to reset values. The partial frame is discarded and no `done` is issued.

## Timing
- Per word: 1 accept cycle (IDLE) plus WORD_W SHIFT cycles. Sustained throughput is 1 word per WORD_W+1 cycles.
- `match` is registered. A bit consumed in cycle k gives `match` high in cycle k+1. `match_count` updates on the same edge.
- The last bit of a frame is consumed in the final SHIFT cycle. `done` is high in the next cycle, with `match_count` already including that bit's match; `match` may be high in the same cycle.
- Frame latency from the last-word handshake to `done` is WORD_W+1 cycles.
- `cfg_*` changes mid-frame are ignored.

## Structure
- `seq_det_pkg` holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - default width constants;
  - a `$clog2`-based width for `bit_cnt` and `fill`.
- `seq_det_core` sub-module: history register, fill counter, comparator and registered `match`. It takes `clk`, `rst`, `clr`, `bit_en`, `bit`, `pattern` and `overlap`.
- `seq_det_ctrl` holds the FSM, shift register, handshake and counter.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0. `s_ready`=1 on the first cycle after release.
- Overlap: pattern 4'b1101, overlap=1, one word 8'b1101_1011 with last=1 → `match` pulses after bits 4 and 7; `done` 9 cycles after handshake; `match_count`=2.
- Non-overlap: same word, overlap=0 → one pulse (after bit 4); `match_count`=1.
- Cross-word: pattern 4'b1101, words 8'b0000_0011 (last=0) then 8'b0100_0000 (last=1) → single match after bit 2 of word 2; `match_count`=1; `s_ready` low during SHIFT; `s_valid` held high waits without data loss.
- Saturation: pattern 4'b1111, overlap=1, 40 words 8'hFF → `match_count`=255 at `done` (not 317 mod 256).
- Reset mid-frame: assert `rst` during SHIFT bit 3 → outputs clear immediately, no `done`. The next frame 8'b1101_0000 with pattern 1101 gives `match_count`=1.
